// File: rtl/ddr_init_pkg.sv
// ddr_init_pkg
//   Shared types and helpers for the DDR init sequencer.
//   - state_t : sequencer states
//   - ERR_*   : fault codes reported on err_code
//   - cnt_w() : width of the shared down-counter for a given longest phase
package ddr_init_pkg;

  typedef enum logic [2:0] {
    PLL_RST = 3'd0,
    LOCK    = 3'd1,
    RST     = 3'd2,
    CFG     = 3'd3,
    CTRL    = 3'd4,
    READY   = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_LOCK_TO   = 2'd1;
  localparam logic [1:0] ERR_CFG_TO    = 2'd2;
  localparam logic [1:0] ERR_LOCK_LOST = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

endpackage

// File: rtl/ddr_init_sequencer_if.sv
// ddr_init_sequencer_if
//   Bundles the DDR control pins and status lines of the init sequencer.
//   Inputs to the sequencer : ddr_pll_lock, cfg_done (both asynchronous),
//                             init_restart (synchronous single-cycle pulse)
//   Outputs of the sequencer: ddr_pll_rstn, cfg_sel, cfg_reset, cfg_start,
//                             phy_rstn, ctrl_rstn, axi_aresetn, init_done,
//                             init_err, err_code[1:0], retry_cnt[1:0]
//   master : sequencer side, slave : pin/core side.
interface ddr_init_sequencer_if;
  logic       ddr_pll_lock;
  logic       cfg_done;
  logic       init_restart;
  logic       ddr_pll_rstn;
  logic       cfg_sel;
  logic       cfg_reset;
  logic       cfg_start;
  logic       phy_rstn;
  logic       ctrl_rstn;
  logic       axi_aresetn;
  logic       init_done;
  logic       init_err;
  logic [1:0] err_code;
  logic [1:0] retry_cnt;

  modport master (
    input  ddr_pll_lock, cfg_done, init_restart,
    output ddr_pll_rstn, cfg_sel, cfg_reset, cfg_start, phy_rstn, ctrl_rstn,
           axi_aresetn, init_done, init_err, err_code, retry_cnt
  );

  modport slave (
    output ddr_pll_lock, cfg_done, init_restart,
    input  ddr_pll_rstn, cfg_sel, cfg_reset, cfg_start, phy_rstn, ctrl_rstn,
           axi_aresetn, init_done, init_err, err_code, retry_cnt
  );
endinterface

// File: rtl/ddr_init_sequencer_sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for W independent asynchronous level signals.
//   Ports: clk, rst (async, active-high), i_d[W-1:0] async in,
//          o_q[W-1:0] synchronised out (2 cycles latency).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/ddr_init_sequencer.sv
// ddr_init_sequencer
//   Power-up / recovery sequencer for the LPDDR4 hard controller. Releases
//   ddr_pll_rstn, then cfg_reset/cfg_start, phy_rstn, ctrl_rstn and finally
//   axi_aresetn, and reports init_done / init_err / err_code / retry_cnt.
//   Ports: clk_100, rst (async, active-high), bus (ddr_init_sequencer_if.master).
//   Build option: define DDR_AUTO_RETRY_EN to retry automatically from ERR up
//   to MAX_RETRY times; otherwise ERR is left only via init_restart or rst.
module ddr_init_sequencer
  import ddr_init_pkg::*;
#(
  parameter int PLL_RST_CYC     = 1000,
  parameter int LOCK_STABLE_CYC = 256,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int RST_HOLD_CYC    = 200,
  parameter int CFG_TIMEOUT     = 10000000,
  parameter bit CFG_SEL_VAL     = 1'b0,
  parameter int MAX_RETRY       = 3
) (
  input logic                   clk_100,
  input logic                   rst,
  ddr_init_sequencer_if.master  bus
);

  localparam int CNT_W = cnt_w(max_int(max_int(PLL_RST_CYC, LOCK_TIMEOUT),
                               max_int(max_int(RST_HOLD_CYC, CFG_TIMEOUT), LOCK_STABLE_CYC)));

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] LD_PLL      = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LOCK     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_HOLD     = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CFG      = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [1:0]       RETRY_LIM   = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

`ifdef DDR_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  logic [1:0]       w_sync_q;
  logic             w_lock_s;
  logic             w_done_s;
  logic [1:0]       w_fault;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_stable;
  logic             r_lost;
  logic             r_pll_rstn;
  logic             r_cfg_reset;
  logic             r_cfg_start;
  logic             r_phy_rstn;
  logic             r_ctrl_rstn;
  logic             r_axi_aresetn;
  logic             r_init_done;
  logic             r_init_err;
  logic [1:0]       r_err_code;
  logic [1:0]       r_retry;

  sync_2ff #(.W(2)) u_sync (
    .clk (clk_100),
    .rst (rst),
    .i_d ({bus.cfg_done, bus.ddr_pll_lock}),
    .o_q (w_sync_q)
  );

  assign w_lock_s = w_sync_q[0];
  assign w_done_s = w_sync_q[1];

  // Fault detection for the current cycle; a successful exit in the same
  // cycle (stable lock, cfg_done) beats the timeout.
  always_comb begin
    w_fault = ERR_NONE;
    case (r_state)
      LOCK:    if (r_cnt == '0 && !(w_lock_s && r_stable == STABLE_LAST)) w_fault = ERR_LOCK_TO;
      CFG:     if (r_cnt == '0 && !w_done_s) w_fault = ERR_CFG_TO;
      READY:   if (!w_lock_s && r_lost) w_fault = ERR_LOCK_LOST;
      default: w_fault = ERR_NONE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_state       <= PLL_RST;
      r_cnt         <= LD_PLL;
      r_stable      <= '0;
      r_lost        <= 1'b0;
      r_pll_rstn    <= 1'b0;
      r_cfg_reset   <= 1'b1;
      r_cfg_start   <= 1'b0;
      r_phy_rstn    <= 1'b0;
      r_ctrl_rstn   <= 1'b0;
      r_axi_aresetn <= 1'b0;
      r_init_done   <= 1'b0;
      r_init_err    <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_retry       <= 2'd0;
    end else if (bus.init_restart) begin
      // Restart wins over any fault detected in the same cycle.
      r_state       <= PLL_RST;
      r_cnt         <= LD_PLL;
      r_stable      <= '0;
      r_lost        <= 1'b0;
      r_pll_rstn    <= 1'b0;
      r_cfg_reset   <= 1'b1;
      r_cfg_start   <= 1'b0;
      r_phy_rstn    <= 1'b0;
      r_ctrl_rstn   <= 1'b0;
      r_axi_aresetn <= 1'b0;
      r_init_done   <= 1'b0;
      r_init_err    <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_retry       <= 2'd0;
    end else if (w_fault != ERR_NONE) begin
      // Every reset is asserted on one edge, so no release ordering applies.
      r_state       <= ERR;
      r_cnt         <= '0;
      r_pll_rstn    <= 1'b0;
      r_cfg_reset   <= 1'b1;
      r_cfg_start   <= 1'b0;
      r_phy_rstn    <= 1'b0;
      r_ctrl_rstn   <= 1'b0;
      r_axi_aresetn <= 1'b0;
      r_init_done   <= 1'b0;
      r_init_err    <= 1'b1;
      r_err_code    <= w_fault;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == '0) begin
            r_state    <= LOCK;
            r_cnt      <= LD_LOCK;
            r_stable   <= '0;
            r_pll_rstn <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        LOCK: begin
          if (w_lock_s && r_stable == STABLE_LAST) begin
            r_state <= RST;
            r_cnt   <= LD_HOLD;
          end else begin
            r_cnt    <= r_cnt - ONE;
            r_stable <= w_lock_s ? r_stable + ONE : '0;
          end
        end
        RST: begin
          if (r_cnt == '0) begin
            r_state     <= CFG;
            r_cnt       <= LD_CFG;
            r_cfg_reset <= 1'b0;
            r_phy_rstn  <= 1'b1;
            r_cfg_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        CFG: begin
          if (w_done_s) begin
            r_state     <= CTRL;
            r_cnt       <= LD_HOLD;
            r_cfg_start <= 1'b0;
            r_ctrl_rstn <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        CTRL: begin
          if (r_cnt == '0) begin
            r_state       <= READY;
            r_cnt         <= '0;
            r_lost        <= 1'b0;
            r_axi_aresetn <= 1'b1;
            r_init_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        READY: begin
          // First low cycle only arms; the second consecutive one faults.
          r_lost <= !w_lock_s;
        end
        ERR: begin
          if (AUTO_RETRY && r_retry < RETRY_LIM) begin
            r_state    <= PLL_RST;
            r_cnt      <= LD_PLL;
            r_retry    <= r_retry + 2'd1;
            r_init_err <= 1'b0;
          end
        end
        default: begin
          r_state <= PLL_RST;
          r_cnt   <= LD_PLL;
        end
      endcase
    end
  end

  assign bus.ddr_pll_rstn = r_pll_rstn;
  assign bus.cfg_sel      = CFG_SEL_VAL;
  assign bus.cfg_reset    = r_cfg_reset;
  assign bus.cfg_start    = r_cfg_start;
  assign bus.phy_rstn     = r_phy_rstn;
  assign bus.ctrl_rstn    = r_ctrl_rstn;
  assign bus.axi_aresetn  = r_axi_aresetn;
  assign bus.init_done    = r_init_done;
  assign bus.init_err     = r_init_err;
  assign bus.err_code     = r_err_code;
  assign bus.retry_cnt    = r_retry;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// tb_ddr_init_sequencer
//   Directed bench for ddr_init_sequencer. A scoreboard queue holds every
//   expected change of the output vector (cycle + value); a monitor on the
//   falling edge pops and compares each change it sees.
//   Honours DDR_AUTO_RETRY_EN to select the expected ERR behaviour.
module tb_ddr_init_sequencer;

  localparam int P_PLL  = 10;
  localparam int P_LSC  = 4;
  localparam int P_HOLD = 5;
  localparam int P_LTO  = 50;
  localparam int P_CTO  = 40;
`ifdef DDR_AUTO_RETRY_EN
  localparam int RETRY_RUNS = 3;
`else
  localparam int RETRY_RUNS = 0;
`endif

  typedef struct {
    string       tag;
    int          cyc;
    logic [11:0] vec;
  } ev_t;

  logic        clk_100 = 1'b0;
  logic        rst     = 1'b0;
  int          cyc;
  int          checks  = 0;
  int          errors  = 0;
  ev_t         q[$];
  logic [11:0] vec;
  logic [11:0] prev;

  always #5 clk_100 = ~clk_100;

  ddr_init_sequencer_if bus_if ();

  ddr_init_sequencer #(
    .PLL_RST_CYC     (P_PLL),
    .LOCK_STABLE_CYC (P_LSC),
    .LOCK_TIMEOUT    (P_LTO),
    .RST_HOLD_CYC    (P_HOLD),
    .CFG_TIMEOUT     (P_CTO),
    .CFG_SEL_VAL     (1'b0),
    .MAX_RETRY       (3)
  ) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus_if)
  );

  // {pll_rstn, cfg_reset, cfg_start, phy_rstn, ctrl_rstn, axi_aresetn,
  //  init_done, init_err, err_code[1:0], retry_cnt[1:0]}
  assign vec = {bus_if.ddr_pll_rstn, bus_if.cfg_reset, bus_if.cfg_start, bus_if.phy_rstn,
                bus_if.ctrl_rstn, bus_if.axi_aresetn, bus_if.init_done, bus_if.init_err,
                bus_if.err_code, bus_if.retry_cnt};

  always @(posedge clk_100 or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [11:0] mk(input logic pll, input logic rs, input logic st,
                                     input logic phy, input logic ctrl, input logic axi,
                                     input logic done, input logic err,
                                     input int code, input int rty);
    return {pll, rs, st, phy, ctrl, axi, done, err, 2'(code), 2'(rty)};
  endfunction

  function automatic logic [11:0] v_rst(input int code, input int rty);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, code, rty);
  endfunction
  function automatic logic [11:0] v_pll(input int code, input int rty);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, code, rty);
  endfunction
  function automatic logic [11:0] v_err(input int code, input int rty);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, code, rty);
  endfunction
  function automatic logic [11:0] v_cfg();
    return mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction
  function automatic logic [11:0] v_ctrl();
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction
  function automatic logic [11:0] v_rdy();
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
  endfunction

  task automatic push(input string tag, input int c, input logic [11:0] v);
    ev_t e;
    e.tag = tag;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  // ERR entry, followed one cycle later by the automatic retry when enabled.
  task automatic push_err(input string tag, input int c, input int code, input int rty);
    push(tag, c, v_err(code, rty));
    if (rty < RETRY_RUNS) push({tag, "_retry"}, c + 1, v_rst(code, rty + 1));
  endtask

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL %s: %0d expected events never seen (expected 0 left)", tag, q.size());
      q.delete();
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    bus_if.ddr_pll_lock = 1'b0;
    bus_if.cfg_done     = 1'b0;
    bus_if.init_restart = 1'b0;
    rst = 1'b1;
    #1;
    chk({tag, "_vec"}, vec, v_rst(0, 0));
    chk({tag, "_cfg_sel"}, {11'd0, bus_if.cfg_sel}, 12'd0);
    @(posedge clk_100);
    #1;
    @(posedge clk_100);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every output change must match the next expected event.
  always @(negedge clk_100) begin
    if (rst) begin
      prev <= vec;
    end else begin
      checks++;
      assert (!(bus_if.ctrl_rstn && !bus_if.phy_rstn) && !(bus_if.axi_aresetn && !bus_if.ctrl_rstn)) else begin
        errors++;
        $error("FAIL order: cycle %0d phy=%b ctrl=%b axi=%b violates release order",
               cyc, bus_if.phy_rstn, bus_if.ctrl_rstn, bus_if.axi_aresetn);
      end
      if (vec !== prev) begin
        checks++;
        assert (q.size() !== 0) else begin
          errors++;
          $error("FAIL unexpected_change: cycle %0d got 'h%0h expected no change from 'h%0h", cyc, vec, prev);
        end
        if (q.size() !== 0) begin
          ev_t e;
          e = q.pop_front();
          checks += 2;
          assert (cyc === e.cyc) else begin
            errors++;
            $error("FAIL %s_cycle: got %0d expected %0d", e.tag, cyc, e.cyc);
          end
          assert (vec === e.vec) else begin
            errors++;
            $error("FAIL %s_value: got 'h%0h expected 'h%0h", e.tag, vec, e.vec);
          end
        end
      end
      prev <= vec;
    end
  end

  initial begin
    int t;
    bus_if.ddr_pll_lock = 1'b0;
    bus_if.cfg_done     = 1'b0;
    bus_if.init_restart = 1'b0;
    #2;

    // Nominal bring-up: lock at 15, cfg_done 8 cycles after cfg_start (26).
    do_reset("reset0");
    push("nom_pll",  P_PLL, v_pll(0, 0));
    push("nom_cfg",  15 + 2 + P_LSC + P_HOLD, v_cfg());
    push("nom_ctrl", 34 + 3, v_ctrl());
    push("nom_rdy",  37 + P_HOLD, v_rdy());
    wait_cyc(15);
    bus_if.ddr_pll_lock = 1'b1;
    wait_cyc(34);
    bus_if.cfg_done = 1'b1;
    wait_cyc(50);
    chk("nom_done", {11'd0, bus_if.init_done}, 12'd1);
    drain("nom_drain");

    // Lock lost for 2 synchronised cycles in READY, then restart.
    push_err("lost_err", 54, 3, 0);
    push("lost_restart", 61, v_rst(0, 0));
    push("rerun_pll",  61 + P_PLL, v_pll(0, 0));
    push("rerun_cfg",  71 + P_LSC + P_HOLD, v_cfg());
    push("rerun_ctrl", 88 + 3, v_ctrl());
    push("rerun_rdy",  91 + P_HOLD, v_rdy());
    bus_if.ddr_pll_lock = 1'b0;
    wait_cyc(52);
    bus_if.ddr_pll_lock = 1'b1;
    wait_cyc(54);
    chk("lost_code", {10'd0, bus_if.err_code}, 12'd3);
    wait_cyc(60);
    bus_if.init_restart = 1'b1;
    bus_if.cfg_done     = 1'b0;
    wait_cyc(61);
    bus_if.init_restart = 1'b0;
    chk("restart_code", {10'd0, bus_if.err_code}, 12'd0);
    wait_cyc(88);
    bus_if.cfg_done = 1'b1;
    wait_cyc(100);
    chk("rerun_done", {11'd0, bus_if.init_done}, 12'd1);
    drain("rerun_drain");

    // Mid-operation reset from READY (checked asynchronously inside do_reset).
    // Then glitchy lock: 3 highs, 1 low, stable; cfg_done never arrives.
    do_reset("reset_mid");
    push("gl_pll", P_PLL, v_pll(0, 0));
    push("gl_cfg", 25 + P_HOLD, v_cfg());
    push_err("cfg_to", 30 + P_CTO, 2, 0);
    wait_cyc(15);
    bus_if.ddr_pll_lock = 1'b1;
    wait_cyc(18);
    bus_if.ddr_pll_lock = 1'b0;
    wait_cyc(19);
    bus_if.ddr_pll_lock = 1'b1;
    wait_cyc(70);
    chk("cfg_to_start", {11'd0, bus_if.cfg_start}, 12'd0);
    chk("cfg_to_code", {10'd0, bus_if.err_code}, 12'd2);
    wait_cyc(75);
    drain("gl_drain");

    // Lock never asserts: lock timeout, plus automatic re-runs when enabled.
    do_reset("reset_nolock");
    for (int r = 0; r <= RETRY_RUNS; r++) begin
      push("nl_pll", P_PLL + r * (P_PLL + P_LTO + 1), v_pll((r == 0) ? 0 : 1, r));
      push_err("nl_err", P_PLL + P_LTO + r * (P_PLL + P_LTO + 1), 1, r);
    end
    t = P_PLL + P_LTO + RETRY_RUNS * (P_PLL + P_LTO + 1) + 20;
    wait_cyc(t);
    chk("nl_state", vec, v_err(1, RETRY_RUNS));
    push("nl_restart", t + 1, v_rst(0, 0));
    push("nl_rerun_pll", t + 1 + P_PLL, v_pll(0, 0));
    bus_if.init_restart = 1'b1;
    wait_cyc(t + 1);
    bus_if.init_restart = 1'b0;
    chk("nl_restart_rty", {10'd0, bus_if.retry_cnt}, 12'd0);
    wait_cyc(t + 13);
    drain("nl_drain");

    // init_restart in the same cycle as the lock timeout.
    do_reset("reset_combo");
    push("cb_pll", P_PLL, v_pll(0, 0));
    push("cb_restart", P_PLL + P_LTO, v_rst(0, 0));
    push("cb_pll2", 2 * P_PLL + P_LTO, v_pll(0, 0));
    wait_cyc(P_PLL + P_LTO - 1);
    bus_if.init_restart = 1'b1;
    wait_cyc(P_PLL + P_LTO);
    bus_if.init_restart = 1'b0;
    chk("cb_status", {7'd0, bus_if.init_err, bus_if.err_code, bus_if.retry_cnt}, 12'd0);
    wait_cyc(2 * P_PLL + P_LTO + 2);
    drain("cb_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
